// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - sequencing FSM for the multi-cycle RV32I core
// Steps the shared datapath through fetch/decode/execute/memory/writeback per opcode.
module multicycle_control_unit #(
    parameter int RESET_PC_WAIT = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       lord_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       pc_source_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] ALU_CO_o,
    output logic       is_immediate_o,
    output logic       reg_write_o,
    output logic [1:0] mem_to_reg_o,
    output logic       illegal_instr_o,
    output logic       instr_retired_o,
    output logic [3:0] state_o
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_WAIT     = 4'd13
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam state_t     RESET_STATE = (RESET_PC_WAIT == 0) ? S_FETCH : S_WAIT;
    localparam logic [3:0] WAIT_LAST   = 4'(RESET_PC_WAIT - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] wait_cnt;

    logic mem_read_r, mem_write_r, ir_write_r, pc_write_r, pc_write_cond_r;
    logic reg_write_r, illegal_r, retired_r;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= RESET_STATE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= (state == S_WAIT) ? wait_cnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        next_state      = state;
        mem_read_r      = 1'b0;
        mem_write_r     = 1'b0;
        ir_write_r      = 1'b0;
        pc_write_r      = 1'b0;
        pc_write_cond_r = 1'b0;
        reg_write_r     = 1'b0;
        illegal_r       = 1'b0;
        retired_r       = 1'b0;
        lord_o          = 1'b0;
        pc_source_o     = 1'b0;
        alu_src_a_o     = 2'b00;
        alu_src_b_o     = 2'b00;
        ALU_CO_o        = 2'b00;
        is_immediate_o  = 1'b0;
        mem_to_reg_o    = 2'b00;
        case (state)
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_read_r  = 1'b1;
                alu_src_b_o = 2'b01;
                if (mem_ready_i) begin
                    ir_write_r = 1'b1;
                    pc_write_r = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/JAL target (and AUIPC result) computed from old PC here.
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b10;
                case (opcode_i)
                    OP_R:               next_state = S_EXECR;
                    OP_I:               next_state = S_EXECI;
                    OP_LOAD, OP_STORE:  next_state = S_MEMADR;
                    OP_BR:              next_state = S_BRANCH;
                    OP_JAL:             next_state = S_JAL;
                    OP_JALR:            next_state = S_JALR;
                    OP_LUI:             next_state = S_LUI;
                    OP_AUIPC:           next_state = S_ALUWB;
                    default: begin
                        illegal_r  = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                next_state  = (opcode_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_read_r = 1'b1;
                lord_o     = 1'b1;
                if (mem_ready_i) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_r  = 1'b1;
                mem_to_reg_o = 2'b01;
                retired_r    = 1'b1;
                next_state   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_write_r = 1'b1;
                lord_o      = 1'b1;
                if (mem_ready_i) begin
                    retired_r  = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a_o = 2'b01;
                ALU_CO_o    = 2'b10;
                next_state  = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_o    = 2'b01;
                alu_src_b_o    = 2'b10;
                ALU_CO_o       = 2'b10;
                is_immediate_o = 1'b1;
                next_state     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_r = 1'b1;
                retired_r   = 1'b1;
                next_state  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o     = 2'b01;
                ALU_CO_o        = 2'b01;
                pc_write_cond_r = 1'b1;
                pc_source_o     = 1'b1;
                retired_r       = 1'b1;
                next_state      = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4 from fetch, so it is the link value.
                pc_write_r   = 1'b1;
                pc_source_o  = 1'b1;
                reg_write_r  = 1'b1;
                mem_to_reg_o = 2'b10;
                retired_r    = 1'b1;
                next_state   = S_FETCH;
            end
            S_JALR: begin
                alu_src_a_o  = 2'b01;
                alu_src_b_o  = 2'b10;
                pc_write_r   = 1'b1;
                reg_write_r  = 1'b1;
                mem_to_reg_o = 2'b10;
                retired_r    = 1'b1;
                next_state   = S_FETCH;
            end
            S_LUI: begin
                reg_write_r  = 1'b1;
                mem_to_reg_o = 2'b11;
                retired_r    = 1'b1;
                next_state   = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Strobes are suppressed during reset so an aborted access never fires.
    assign mem_read_o      = mem_read_r      & ~rst_i;
    assign mem_write_o     = mem_write_r     & ~rst_i;
    assign ir_write_o      = ir_write_r      & ~rst_i;
    assign pc_write_o      = pc_write_r      & ~rst_i;
    assign pc_write_cond_o = pc_write_cond_r & ~rst_i;
    assign reg_write_o     = reg_write_r     & ~rst_i;
    assign illegal_instr_o = illegal_r       & ~rst_i;
    assign instr_retired_o = retired_r       & ~rst_i;
    assign state_o         = state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
// Stimulus builds each instruction's cycle sequence from its class; a monitor checks every cycle.
module tb_multicycle_control_unit;
    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3, ST_MEMWB = 4;
    localparam int ST_MEMWRITE = 5, ST_EXECR = 6, ST_EXECI = 7, ST_ALUWB = 8, ST_BRANCH = 9;
    localparam int ST_JAL = 10, ST_JALR = 11, ST_LUI = 12, ST_WAIT = 13;
    localparam logic [22:0] STATE_MASK  = 23'h780000;
    localparam logic [22:0] STROBE_MASK = 23'h06E013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, mem_ready;
    logic [6:0] opcode;
    logic       mem_read, mem_write, lord, ir_write, pc_write, pc_write_cond, pc_source;
    logic [1:0] alu_src_a, alu_src_b, alu_co, mem_to_reg;
    logic       is_imm, reg_write, illegal, retired;
    logic [3:0] state;
    logic       w_mem_read, w_mem_write, w_lord, w_ir_write, w_pc_write, w_pc_write_cond;
    logic       w_pc_source, w_is_imm, w_reg_write, w_illegal, w_retired;
    logic [1:0] w_alu_src_a, w_alu_src_b, w_alu_co, w_mem_to_reg;
    logic [3:0] w_state;

    multicycle_control_unit #(.RESET_PC_WAIT(0)) dut (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .lord_o(lord),
        .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond),
        .pc_source_o(pc_source), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
        .ALU_CO_o(alu_co), .is_immediate_o(is_imm), .reg_write_o(reg_write),
        .mem_to_reg_o(mem_to_reg), .illegal_instr_o(illegal), .instr_retired_o(retired),
        .state_o(state)
    );

    multicycle_control_unit #(.RESET_PC_WAIT(3)) dut_wait (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .mem_read_o(w_mem_read), .mem_write_o(w_mem_write), .lord_o(w_lord),
        .ir_write_o(w_ir_write), .pc_write_o(w_pc_write), .pc_write_cond_o(w_pc_write_cond),
        .pc_source_o(w_pc_source), .alu_src_a_o(w_alu_src_a), .alu_src_b_o(w_alu_src_b),
        .ALU_CO_o(w_alu_co), .is_immediate_o(w_is_imm), .reg_write_o(w_reg_write),
        .mem_to_reg_o(w_mem_to_reg), .illegal_instr_o(w_illegal), .instr_retired_o(w_retired),
        .state_o(w_state)
    );

    typedef struct {
        logic [22:0] exp;
        logic [22:0] mask;
        bit          chk2;
        logic [3:0]  st2;
    } rec_t;

    rec_t q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   post_rst = 100;

    function automatic logic [22:0] exp_out(int st, bit rdy, logic [6:0] op);
        logic mr, mw, ld, irw, pw, pwc, ps, imm, rw, ill, ret;
        logic [1:0] a, b, co, mtr;
        {mr, mw, ld, irw, pw, pwc, ps, imm, rw, ill, ret} = '0;
        {a, b, co, mtr} = '0;
        case (st)
            ST_FETCH:    begin mr = 1; b = 2'b01; irw = rdy; pw = rdy; end
            ST_DECODE: begin
                a = 2'b10; b = 2'b10;
                ill = !(op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                   7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                   7'b0010111});
            end
            ST_MEMADR:   begin a = 2'b01; b = 2'b10; end
            ST_MEMREAD:  begin mr = 1; ld = 1; end
            ST_MEMWB:    begin rw = 1; mtr = 2'b01; ret = 1; end
            ST_MEMWRITE: begin mw = 1; ld = 1; ret = rdy; end
            ST_EXECR:    begin a = 2'b01; co = 2'b10; end
            ST_EXECI:    begin a = 2'b01; b = 2'b10; co = 2'b10; imm = 1; end
            ST_ALUWB:    begin rw = 1; ret = 1; end
            ST_BRANCH:   begin a = 2'b01; co = 2'b01; pwc = 1; ps = 1; ret = 1; end
            ST_JAL:      begin pw = 1; ps = 1; rw = 1; mtr = 2'b10; ret = 1; end
            ST_JALR:     begin a = 2'b01; b = 2'b10; pw = 1; rw = 1; mtr = 2'b10; ret = 1; end
            ST_LUI:      begin rw = 1; mtr = 2'b11; ret = 1; end
            default:     ;
        endcase
        return {4'(st), mr, mw, ld, irw, pw, pwc, ps, a, b, co, imm, rw, mtr, ill, ret};
    endfunction

    always @(negedge clk) begin
        rec_t r;
        logic [22:0] act;
        if (q.size() > 0) begin
            r = q.pop_front();
            act = {state, mem_read, mem_write, lord, ir_write, pc_write, pc_write_cond,
                   pc_source, alu_src_a, alu_src_b, alu_co, is_imm, reg_write,
                   mem_to_reg, illegal, retired};
            compared++;
            if ((act & r.mask) !== (r.exp & r.mask)) begin
                mismatched++;
                $display("FAIL ctrl @%0t: got %h want %h (mask %h)", $time, act, r.exp, r.mask);
            end
            if (r.chk2) begin
                compared++;
                if (w_state !== r.st2) begin
                    mismatched++;
                    $display("FAIL wait_state @%0t: got %0d want %0d", $time, w_state, r.st2);
                end
            end
        end
    end

    task automatic cyc(int st, bit rdy, logic [6:0] op);
        rec_t r;
        mem_ready = rdy;
        opcode    = op;
        r.exp  = exp_out(st, rdy, op);
        r.mask = '1;
        r.chk2 = (post_rst < 4);
        r.st2  = (post_rst < 3) ? 4'(ST_WAIT) : 4'(ST_FETCH);
        post_rst++;
        q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int n, int st_now);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            rst       = 1'b1;
            mem_ready = 1'($urandom);
            opcode    = 7'($urandom);
            r.exp  = {4'((i == 0) ? st_now : ST_FETCH), 19'h0};
            r.mask = STATE_MASK | STROBE_MASK;
            r.chk2 = (i > 0);
            r.st2  = 4'(ST_WAIT);
            q.push_back(r);
            @(posedge clk);
            #1;
        end
        rst      = 1'b0;
        post_rst = 0;
    endtask

    task automatic run_instr(logic [6:0] op, int fw, int mw);
        for (int i = 0; i < fw; i++) cyc(ST_FETCH, 1'b0, op);
        cyc(ST_FETCH, 1'b1, op);
        cyc(ST_DECODE, 1'($urandom), op);
        case (op)
            7'b0110011: begin cyc(ST_EXECR, 1'($urandom), op); cyc(ST_ALUWB, 1'($urandom), op); end
            7'b0010011: begin cyc(ST_EXECI, 1'($urandom), op); cyc(ST_ALUWB, 1'($urandom), op); end
            7'b0010111: cyc(ST_ALUWB, 1'($urandom), op);
            7'b0000011: begin
                cyc(ST_MEMADR, 1'($urandom), op);
                for (int i = 0; i < mw; i++) cyc(ST_MEMREAD, 1'b0, op);
                cyc(ST_MEMREAD, 1'b1, op);
                cyc(ST_MEMWB, 1'($urandom), op);
            end
            7'b0100011: begin
                cyc(ST_MEMADR, 1'($urandom), op);
                for (int i = 0; i < mw; i++) cyc(ST_MEMWRITE, 1'b0, op);
                cyc(ST_MEMWRITE, 1'b1, op);
            end
            7'b1100011: cyc(ST_BRANCH, 1'($urandom), op);
            7'b1101111: cyc(ST_JAL, 1'($urandom), op);
            7'b1100111: cyc(ST_JALR, 1'($urandom), op);
            7'b0110111: cyc(ST_LUI, 1'($urandom), op);
            default: ;
        endcase
    endtask

    logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                  7'b0010111};

    initial begin
        logic [6:0] op;
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = 7'b0110011;
        @(posedge clk);
        #1;
        do_reset(2, ST_FETCH);
        run_instr(7'b0110011, 0, 0);
        run_instr(7'b0000011, 0, 3);
        run_instr(7'b0010011, 0, 0);
        run_instr(7'b0100011, 0, 2);
        run_instr(7'b1100011, 0, 0);
        run_instr(7'b1101111, 0, 0);
        run_instr(7'b1111111, 0, 0);
        run_instr(7'b0110011, 0, 0);
        // Store aborted by reset while the write is still pending.
        cyc(ST_FETCH, 1'b1, 7'b0100011);
        cyc(ST_DECODE, 1'b0, 7'b0100011);
        cyc(ST_MEMADR, 1'b0, 7'b0100011);
        cyc(ST_MEMWRITE, 1'b0, 7'b0100011);
        cyc(ST_MEMWRITE, 1'b0, 7'b0100011);
        do_reset(1, ST_MEMWRITE);
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 4) == 0) op = 7'($urandom);
            else op = legal_ops[$urandom_range(0, 8)];
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) do_reset($urandom_range(1, 3), ST_FETCH);
        end
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: %0d records left, required 0", q.size());
        end
        #20;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
